// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, oversampling
// constants, receive FIFO entry layout and the parity check helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_WAITIDLE = 3'd5
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int ENTRY_W    = 10;

    // True when the received parity bit does not match the selected sense.
    function automatic logic parity_error(input logic [7:0] data,
                                          input logic       parityBit,
                                          input logic       parityOdd);
        return ((^data) ^ parityBit) != parityOdd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: 2**n entries of {framingError, parityError, data[7:0]}.
// Pushes when full are dropped; pops when empty are ignored.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int nrOfFifoAddressBits = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] pushData,
    input  logic               pop,
    output logic [ENTRY_W-1:0] headData,
    output logic               empty,
    output logic               full
);

    localparam int AW    = nrOfFifoAddressBits;
    localparam int DEPTH = 2 ** AW;

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic               empty_r;
    logic               full_r;
    logic               do_push_s;
    logic               do_pop_s;
    logic [AW-1:0]      wr_next_s;
    logic [AW-1:0]      rd_next_s;

    assign do_push_s = push & ~full_r;
    assign do_pop_s  = pop & ~empty_r;
    assign wr_next_s = wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
    assign rd_next_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};

    // Storage write port; contents only matter behind a valid pointer.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= pushData;
        end
    end

    // Pointers and registered occupancy flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_next_s;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_next_s;
            end
            // Simultaneous push and pop leaves occupancy and both flags as they were.
            if (do_push_s && !do_pop_s) begin
                empty_r <= 1'b0;
                full_r  <= (wr_next_s == rd_ptr_r);
            end else if (do_pop_s && !do_push_s) begin
                full_r  <= 1'b0;
                empty_r <= (rd_next_s == wr_ptr_r);
            end
        end
    end

    assign headData = empty_r ? {ENTRY_W{1'b0}} : mem_r[rd_ptr_r];
    assign empty    = empty_r;
    assign full     = full_r;

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver: 2-flop input synchronizer, oversampling tick generator,
// 8N1/8E1/8O1 deframing FSM and a receive FIFO with sticky error flags.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int nrOfFifoAddressBits = 4,
    parameter int oversample          = OVERSAMPLE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uartRxd,
    input  logic [15:0] baudDivisor,
    input  logic        parityEnable,
    input  logic        parityOdd,
    input  logic        fifoRe,
    input  logic        clearErrors,
    output logic        fifoEmpty,
    output logic        fifoFull,
    output logic [7:0]  dataOut,
    output logic        parityErrorOut,
    output logic        framingErrorOut,
    output logic        overrunError,
    output logic        breakDetected,
    output logic        rxBusy
);

    localparam int TICK_W = $clog2(oversample);
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(oversample / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(oversample - 1);

    logic              rx_meta_r;
    logic              rx_sync_r;
    logic              rxs_s;
    logic [15:0]       baud_cnt_r;
    logic              tick_s;
    logic [TICK_W-1:0] tick_cnt_r;
    logic              sample_s;
    logic              start_edge_s;
    rx_state_e         state_r;
    rx_state_e         next_state_s;
    logic [7:0]        shift_r;
    logic [2:0]        bit_idx_r;
    logic              parity_err_r;
    logic              busy_r;
    logic              push_s;
    logic              framing_s;
    logic              overrun_r;
    logic              break_r;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [ENTRY_W-1:0] head_s;

    // Metastability guard on the pad input, idle-high after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= uartRxd;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rxs_s        = rx_sync_r;
    assign start_edge_s = (state_r == ST_IDLE) && !rxs_s;
    assign tick_s       = (baud_cnt_r == 16'd0);
    assign sample_s     = tick_s && (tick_cnt_r == MID_TICK) && (state_r != ST_IDLE);

    // Baud tick divider; restarted on the start edge to align the sampling phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            baud_cnt_r <= 16'd0;
        end else if (start_edge_s || tick_s) begin
            baud_cnt_r <= baudDivisor;
        end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
        end
    end

    // Tick position within the current bit; wraps every oversample ticks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (start_edge_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= (tick_cnt_r == LAST_TICK) ? {TICK_W{1'b0}} : tick_cnt_r + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!rxs_s) next_state_s = ST_START;
                else        next_state_s = ST_IDLE;
            end
            ST_START: begin
                if (sample_s) next_state_s = rxs_s ? ST_IDLE : ST_DATA;
                else          next_state_s = ST_START;
            end
            ST_DATA: begin
                if (sample_s && bit_idx_r == 3'd7) next_state_s = parityEnable ? ST_PARITY : ST_STOP;
                else                                next_state_s = ST_DATA;
            end
            ST_PARITY: begin
                if (sample_s) next_state_s = ST_STOP;
                else          next_state_s = ST_PARITY;
            end
            ST_STOP: begin
                if (sample_s) next_state_s = rxs_s ? ST_IDLE : ST_WAITIDLE;
                else          next_state_s = ST_STOP;
            end
            ST_WAITIDLE: begin
                // A line held low must return high before a new start is accepted.
                if (rxs_s) next_state_s = ST_IDLE;
                else       next_state_s = ST_WAITIDLE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: the push strobe coincides with the stop-bit sample.
    always_comb begin
        push_s    = 1'b0;
        framing_s = 1'b0;
        if (state_r == ST_STOP && sample_s) begin
            push_s    = 1'b1;
            framing_s = ~rxs_s;
        end else begin
            push_s    = 1'b0;
            framing_s = 1'b0;
        end
    end

    // Character datapath: LSB-first shift register, bit index and parity result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_r      <= 8'd0;
            bit_idx_r    <= 3'd0;
            parity_err_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            bit_idx_r    <= 3'd0;
            parity_err_r <= 1'b0;
        end else if (sample_s) begin
            case (state_r)
                ST_DATA: begin
                    shift_r   <= {rxs_s, shift_r[7:1]};
                    bit_idx_r <= bit_idx_r + 3'd1;
                end
                ST_PARITY: parity_err_r <= parity_error(shift_r, rxs_s, parityOdd);
                default:   parity_err_r <= parity_err_r;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_r <= 1'b0;
            break_r   <= 1'b0;
        end else begin
            if (push_s && fifo_full_s)  overrun_r <= 1'b1;
            else if (clearErrors)       overrun_r <= 1'b0;
            if (push_s && framing_s && shift_r == 8'd0) break_r <= 1'b1;
            else if (clearErrors)                       break_r <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .nrOfFifoAddressBits(nrOfFifoAddressBits)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push_s),
        .pushData ({framing_s, parity_err_r, shift_r}),
        .pop      (fifoRe),
        .headData (head_s),
        .empty    (fifo_empty_s),
        .full     (fifo_full_s)
    );

    assign fifoEmpty       = fifo_empty_s;
    assign fifoFull        = fifo_full_s;
    assign dataOut         = head_s[7:0];
    assign parityErrorOut  = head_s[8];
    assign framingErrorOut = head_s[9];
    assign overrunError    = overrun_r;
    assign breakDetected   = break_r;
    assign rxBusy          = busy_r;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: serial frames driven bit by bit,
// FIFO head and flags checked against hand-computed values.
module tb_uart_rx_buffered;

    logic        clock = 1'b0;
    logic        reset;
    logic        uartRxd;
    logic [15:0] baudDivisor;
    logic        parityEnable;
    logic        parityOdd;
    logic        fifoRe;
    logic        clearErrors;
    logic        fifoEmpty;
    logic        fifoFull;
    logic [7:0]  dataOut;
    logic        parityErrorOut;
    logic        framingErrorOut;
    logic        overrunError;
    logic        breakDetected;
    logic        rxBusy;

    int total = 0;
    int bad   = 0;
    int bitClk = 16;

    uart_rx_buffered dut (
        .clock           (clock),
        .reset           (reset),
        .uartRxd         (uartRxd),
        .baudDivisor     (baudDivisor),
        .parityEnable    (parityEnable),
        .parityOdd       (parityOdd),
        .fifoRe          (fifoRe),
        .clearErrors     (clearErrors),
        .fifoEmpty       (fifoEmpty),
        .fifoFull        (fifoFull),
        .dataOut         (dataOut),
        .parityErrorOut  (parityErrorOut),
        .framingErrorOut (framingErrorOut),
        .overrunError    (overrunError),
        .breakDetected   (breakDetected),
        .rxBusy          (rxBusy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        uartRxd = b;
        repeat (bitClk) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic hasPar,
                              input logic parBit, input logic stopBit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (hasPar) drive_bit(parBit);
        drive_bit(stopBit);
        if (stopBit) repeat (4) @(negedge clock);
    endtask

    task automatic pop_one();
        fifoRe = 1'b1;
        @(negedge clock);
        fifoRe = 1'b0;
    endtask

    initial begin
        reset = 1'b1; uartRxd = 1'b1; baudDivisor = 16'd0;
        parityEnable = 1'b0; parityOdd = 1'b0; fifoRe = 1'b0; clearErrors = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_empty", 16'(fifoEmpty), 16'd1);
        check("rst_full", 16'(fifoFull), 16'd0);
        check("rst_data", 16'(dataOut), 16'h00);
        check("rst_errs", 16'({parityErrorOut, framingErrorOut, overrunError, breakDetected}), 16'd0);
        check("rst_busy", 16'(rxBusy), 16'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // 8N1 character
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        check("t1_empty", 16'(fifoEmpty), 16'd0);
        check("t1_data", 16'(dataOut), 16'hA5);
        check("t1_errs", 16'({parityErrorOut, framingErrorOut}), 16'd0);
        pop_one();
        check("t1_pop_empty", 16'(fifoEmpty), 16'd1);

        // Even parity good and bad, then odd parity good
        parityEnable = 1'b1; parityOdd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        check("t2_even_ok_data", 16'(dataOut), 16'h07);
        check("t2_even_ok_pe", 16'(parityErrorOut), 16'd0);
        pop_one();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        check("t2_even_bad_data", 16'(dataOut), 16'h07);
        check("t2_even_bad_pe", 16'(parityErrorOut), 16'd1);
        pop_one();
        parityOdd = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        check("t2_odd_ok_pe", 16'(parityErrorOut), 16'd0);
        pop_one();
        parityEnable = 1'b0; parityOdd = 1'b0;

        // Slower baud: 3 clocks per tick
        baudDivisor = 16'd2; bitClk = 48;
        send_frame(8'h3A, 1'b0, 1'b0, 1'b1);
        check("div2_data", 16'(dataOut), 16'h3A);
        pop_one();
        check("div2_pop_empty", 16'(fifoEmpty), 16'd1);
        baudDivisor = 16'd0; bitClk = 16;

        // Short glitch is rejected
        uartRxd = 1'b0;
        repeat (4) @(negedge clock);
        uartRxd = 1'b1;
        repeat (16) @(negedge clock);
        check("t3_busy", 16'(rxBusy), 16'd0);
        check("t3_empty", 16'(fifoEmpty), 16'd1);

        // Break: zero data, zero stop, line held low
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (100) @(negedge clock);
        check("t4_empty", 16'(fifoEmpty), 16'd0);
        check("t4_data", 16'(dataOut), 16'h00);
        check("t4_fe", 16'(framingErrorOut), 16'd1);
        check("t4_break", 16'(breakDetected), 16'd1);
        check("t4_waitidle_busy", 16'(rxBusy), 16'd1);
        pop_one();
        check("t4_single_entry", 16'(fifoEmpty), 16'd1);
        uartRxd = 1'b1;
        repeat (20) @(negedge clock);
        check("t4_idle_busy", 16'(rxBusy), 16'd0);
        check("t4_no_retrigger", 16'(fifoEmpty), 16'd1);
        clearErrors = 1'b1;
        @(negedge clock);
        clearErrors = 1'b0;
        check("t4_break_clr", 16'(breakDetected), 16'd0);

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
        check("t5_full16", 16'(fifoFull), 16'd1);
        check("t5_no_ovr16", 16'(overrunError), 16'd0);
        send_frame(8'h10, 1'b0, 1'b0, 1'b1);
        check("t5_ovr", 16'(overrunError), 16'd1);
        check("t5_brk_clean", 16'(breakDetected), 16'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t5_pop%0d", i), 16'(dataOut), 16'(i));
            pop_one();
        end
        check("t5_drained", 16'(fifoEmpty), 16'd1);
        check("t5_not_full", 16'(fifoFull), 16'd0);
        clearErrors = 1'b1;
        @(negedge clock);
        clearErrors = 1'b0;
        check("t5_ovr_clr", 16'(overrunError), 16'd0);

        // Async reset mid-character, then a clean character
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        check("t6_pre_empty", 16'(fifoEmpty), 16'd0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        check("t6_mid_busy", 16'(rxBusy), 16'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_empty", 16'(fifoEmpty), 16'd1);
        check("t6_async_busy", 16'(rxBusy), 16'd0);
        check("t6_async_data", 16'(dataOut), 16'h00);
        @(negedge clock);
        uartRxd = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        check("t6_data", 16'(dataOut), 16'h81);
        check("t6_errs", 16'({parityErrorOut, framingErrorOut}), 16'd0);
        pop_one();
        check("t6_only_one", 16'(fifoEmpty), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
